// File: rtl/alu_pkg.sv
// Shared decode tables for the execute stage: aluc codes, I-type opcodes,
// exception codes and the opcode/funct decoder.
package alu_pkg;

  localparam logic [5:0] ALUC_ADD  = 6'b100000;
  localparam logic [5:0] ALUC_ADDU = 6'b100001;
  localparam logic [5:0] ALUC_SUB  = 6'b100010;
  localparam logic [5:0] ALUC_SUBU = 6'b100011;
  localparam logic [5:0] ALUC_AND  = 6'b100100;
  localparam logic [5:0] ALUC_OR   = 6'b100101;
  localparam logic [5:0] ALUC_XOR  = 6'b100110;
  localparam logic [5:0] ALUC_NOR  = 6'b100111;
  localparam logic [5:0] ALUC_SLT  = 6'b101010;
  localparam logic [5:0] ALUC_SLTU = 6'b101011;
  localparam logic [5:0] ALUC_SLL  = 6'b000000;
  localparam logic [5:0] ALUC_SRL  = 6'b000010;
  localparam logic [5:0] ALUC_SRA  = 6'b000011;
  localparam logic [5:0] ALUC_SLLV = 6'b000100;
  localparam logic [5:0] ALUC_SRLV = 6'b000110;
  localparam logic [5:0] ALUC_SRAV = 6'b000111;
  localparam logic [5:0] ALUC_LUI  = 6'b001111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam int         EXC_W    = 2;
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_RSVD = 2'b10;

  typedef enum logic [2:0] {
    SEL_RR,
    SEL_SHAMT,
    SEL_SIMM,
    SEL_ZIMM,
    SEL_LUI,
    SEL_ZERO
  } opnd_sel_e;

  typedef struct packed {
    logic [5:0] aluc;
    logic       rsvd;
    opnd_sel_e  sel;
  } dec_t;

  // Reserved encodings fall back to ADDU on zero operands so the ALU stays quiet.
  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d.aluc = ALUC_ADDU;
    d.rsvd = 1'b0;
    d.sel  = SEL_RR;
    if (opcode == OP_RTYPE) begin
      case (funct)
        ALUC_SLL, ALUC_SRL, ALUC_SRA: begin
          d.aluc = funct;
          d.sel  = SEL_SHAMT;
        end
        ALUC_ADD, ALUC_ADDU, ALUC_SUB, ALUC_SUBU, ALUC_AND, ALUC_OR, ALUC_XOR,
        ALUC_NOR, ALUC_SLT, ALUC_SLTU, ALUC_SLLV, ALUC_SRLV, ALUC_SRAV,
        ALUC_LUI: begin
          d.aluc = funct;
          d.sel  = SEL_RR;
        end
        default: begin
          d.rsvd = 1'b1;
          d.sel  = SEL_ZERO;
        end
      endcase
    end else begin
      case (opcode)
        OP_ADDI:  begin d.aluc = ALUC_ADD;  d.sel = SEL_SIMM; end
        OP_ADDIU: begin d.aluc = ALUC_ADDU; d.sel = SEL_SIMM; end
        OP_SLTI:  begin d.aluc = ALUC_SLT;  d.sel = SEL_SIMM; end
        OP_SLTIU: begin d.aluc = ALUC_SLTU; d.sel = SEL_SIMM; end
        OP_ANDI:  begin d.aluc = ALUC_AND;  d.sel = SEL_ZIMM; end
        OP_ORI:   begin d.aluc = ALUC_OR;   d.sel = SEL_ZIMM; end
        OP_XORI:  begin d.aluc = ALUC_XOR;  d.sel = SEL_ZIMM; end
        OP_LUI:   begin d.aluc = ALUC_LUI;  d.sel = SEL_LUI;  end
        default: begin
          d.rsvd = 1'b1;
          d.sel  = SEL_ZERO;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_ex_stage_if.sv
// Decode-side and memory-side handshake bundle of the execute stage.
interface alu_ex_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_opcode;
  logic [5:0]       in_funct;
  logic [4:0]       in_shamt;
  logic [15:0]      in_imm;
  logic [WIDTH-1:0] in_rs_val;
  logic [WIDTH-1:0] in_rt_val;
  logic [4:0]       in_dst;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_dst;
  logic             out_wen;
  logic             out_zero;
  logic             out_negative;
  logic [EXC_W-1:0] out_exc;

  modport master (
    output in_valid, in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val,
           in_dst, out_ready,
    input  in_ready, out_valid, out_result, out_dst, out_wen, out_zero,
           out_negative, out_exc
  );

  modport slave (
    input  in_valid, in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val,
           in_dst, out_ready,
    output in_ready, out_valid, out_result, out_dst, out_wen, out_zero,
           out_negative, out_exc
  );
endinterface

// File: rtl/modular_alu.sv
// Combinational ALU keyed by the 6-bit aluc code; shifts take the amount from a[4:0].
module modular_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       aluc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);
  logic [WIDTH-1:0]        sum;
  logic [WIDTH-1:0]        diff;
  logic [4:0]              sh;
  logic signed [WIDTH-1:0] b_s;

  assign sum  = a + b;
  assign diff = a - b;
  assign sh   = a[4:0];
  assign b_s  = $signed(b);

  always_comb begin
    r        = '0;
    overflow = 1'b0;
    case (aluc)
      ALUC_ADD, ALUC_ADDU: begin
        r        = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALUC_SUB, ALUC_SUBU: begin
        r        = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALUC_AND:             r = a & b;
      ALUC_OR:              r = a | b;
      ALUC_XOR:             r = a ^ b;
      ALUC_NOR:             r = ~(a | b);
      ALUC_SLT:             r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALUC_SLTU:            r = {{(WIDTH-1){1'b0}}, (a < b)};
      ALUC_SLL, ALUC_SLLV:  r = b << sh;
      ALUC_SRL, ALUC_SRLV:  r = b >> sh;
      ALUC_SRA, ALUC_SRAV:  r = b_s >>> sh;
      ALUC_LUI:             r = {b[15:0], 16'h0000};
      default:              r = '0;
    endcase
  end

  assign zero     = (r == '0);
  assign negative = r[WIDTH-1];
endmodule

// File: rtl/alu_ex_stage.sv
// Two-stage execute pipeline: stage 1 holds decoded operands, stage 2 holds
// the ALU result and exception status; both boundaries are valid/ready.
module alu_ex_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_ex_stage_if.slave bus
);
  dec_t             dec;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;

  logic             s1_valid;
  logic             s1_rsvd;
  logic [5:0]       s1_aluc;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [4:0]       s1_dst;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic [4:0]       s2_dst;
  logic             s2_wen;
  logic             s2_zero;
  logic             s2_neg;
  logic [EXC_W-1:0] s2_exc;

  logic             s2_ready;
  logic             s1_adv;
  logic             in_fire;

  logic [WIDTH-1:0] alu_r;
  logic             alu_zero;
  logic             alu_neg;
  logic             alu_ovf;
  logic [EXC_W-1:0] exc_nxt;

  assign dec = decode(bus.in_opcode, bus.in_funct);

  always_comb begin
    a_nxt = bus.in_rs_val;
    b_nxt = bus.in_rt_val;
    case (dec.sel)
      SEL_SHAMT: a_nxt = {{(WIDTH-5){1'b0}}, bus.in_shamt};
      SEL_SIMM:  b_nxt = {{(WIDTH-16){bus.in_imm[15]}}, bus.in_imm};
      SEL_ZIMM:  b_nxt = {{(WIDTH-16){1'b0}}, bus.in_imm};
      SEL_LUI: begin
        a_nxt = '0;
        b_nxt = {{(WIDTH-16){1'b0}}, bus.in_imm};
      end
      SEL_ZERO: begin
        a_nxt = '0;
        b_nxt = '0;
      end
      default: ;
    endcase
  end

  // in_ready depends only on pipeline state, never on in_valid.
  assign s2_ready     = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rsvd <= 1'b0;
      s1_aluc <= '0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_dst  <= '0;
    end else if (in_fire) begin
      s1_rsvd <= dec.rsvd;
      s1_aluc <= dec.aluc;
      s1_a    <= a_nxt;
      s1_b    <= b_nxt;
      s1_dst  <= bus.in_dst;
    end
  end

  modular_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .aluc     (s1_aluc),
    .a        (s1_a),
    .b        (s1_b),
    .r        (alu_r),
    .zero     (alu_zero),
    .negative (alu_neg),
    .overflow (alu_ovf)
  );

  // ADDI decodes to ADD, so only the signed add/sub codes can trap.
  always_comb begin
    exc_nxt = EXC_NONE;
    if (s1_rsvd) begin
      exc_nxt = EXC_RSVD;
    end else if (alu_ovf && ((s1_aluc == ALUC_ADD) || (s1_aluc == ALUC_SUB))) begin
      exc_nxt = EXC_OVF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_result <= '0;
      s2_dst    <= '0;
      s2_wen    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_neg    <= 1'b0;
      s2_exc    <= EXC_NONE;
    end else if (s1_adv) begin
      s2_result <= alu_r;
      s2_dst    <= s1_dst;
      s2_wen    <= (exc_nxt == EXC_NONE);
      s2_zero   <= alu_zero;
      s2_neg    <= alu_neg;
      s2_exc    <= exc_nxt;
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_result   = s2_result;
  assign bus.out_dst      = s2_dst;
  assign bus.out_wen      = s2_wen;
  assign bus.out_zero     = s2_zero;
  assign bus.out_negative = s2_neg;
  assign bus.out_exc      = s2_exc;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed and randomized checks of alu_ex_stage against an instruction-level
// reference model with an in-order expected-result queue.
module tb_alu_ex_stage;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dst;
  } instr_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wen;
    logic        zero;
    logic        neg;
    logic [1:0]  exc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  exp_t q[$];
  instr_t cur;

  logic [5:0] rfn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0f};

  alu_ex_stage_if #(.WIDTH(32)) bus ();

  alu_ex_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input instr_t i);
    exp_t e;
    longint s;
    logic rsvd;
    logic ovf;
    logic [31:0] r;
    logic [31:0] se;
    logic [31:0] ze;
    logic signed [31:0] t;
    rsvd = 1'b0;
    ovf  = 1'b0;
    r    = 32'h0;
    s    = 0;
    se   = {{16{i.imm[15]}}, i.imm};
    ze   = {16'h0000, i.imm};
    t    = $signed(i.rt);
    if (i.op == 6'h00) begin
      case (i.fn)
        6'h20: begin
          s = longint'($signed(i.rs)) + longint'($signed(i.rt));
          r = s[31:0];
          ovf = (s != longint'($signed(r)));
        end
        6'h21: r = i.rs + i.rt;
        6'h22: begin
          s = longint'($signed(i.rs)) - longint'($signed(i.rt));
          r = s[31:0];
          ovf = (s != longint'($signed(r)));
        end
        6'h23: r = i.rs - i.rt;
        6'h24: r = i.rs & i.rt;
        6'h25: r = i.rs | i.rt;
        6'h26: r = i.rs ^ i.rt;
        6'h27: r = ~(i.rs | i.rt);
        6'h2a: r = ($signed(i.rs) < $signed(i.rt)) ? 32'd1 : 32'd0;
        6'h2b: r = (i.rs < i.rt) ? 32'd1 : 32'd0;
        6'h00: r = i.rt << i.sh;
        6'h02: r = i.rt >> i.sh;
        6'h03: r = t >>> i.sh;
        6'h04: r = i.rt << i.rs[4:0];
        6'h06: r = i.rt >> i.rs[4:0];
        6'h07: r = t >>> i.rs[4:0];
        6'h0f: r = {i.rt[15:0], 16'h0000};
        default: rsvd = 1'b1;
      endcase
    end else begin
      case (i.op)
        6'h08: begin
          s = longint'($signed(i.rs)) + longint'($signed(se));
          r = s[31:0];
          ovf = (s != longint'($signed(r)));
        end
        6'h09: r = i.rs + se;
        6'h0a: r = ($signed(i.rs) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0b: r = (i.rs < se) ? 32'd1 : 32'd0;
        6'h0c: r = i.rs & ze;
        6'h0d: r = i.rs | ze;
        6'h0e: r = i.rs ^ ze;
        6'h0f: r = {i.imm, 16'h0000};
        default: rsvd = 1'b1;
      endcase
    end
    if (rsvd) r = 32'h0;
    e.res  = r;
    e.dst  = i.dst;
    e.zero = (r == 32'h0);
    e.neg  = r[31];
    e.exc  = rsvd ? 2'b10 : (ovf ? 2'b01 : 2'b00);
    e.wen  = (e.exc == 2'b00);
    return e;
  endfunction

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [4:0] dst);
    instr_t i;
    i.op = op; i.fn = fn; i.sh = sh; i.imm = imm; i.rs = rs; i.rt = rt; i.dst = dst;
    return i;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'h8000_0000;
      3: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 27);
    i = mk(6'h00, 6'($urandom), 5'($urandom), 16'($urandom), rand_val(), rand_val(),
           5'($urandom));
    if (k < 17) i.fn = rfn[k];
    else if (k < 25) i.op = 6'(8 + k - 17);
    else if (k == 26) i.op = 6'($urandom);
    return i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input exp_t e, input string tag);
    chk({tag, ".result"}, bus.out_result, e.res);
    chk({tag, ".dst"},    32'(bus.out_dst), 32'(e.dst));
    chk({tag, ".wen"},    32'(bus.out_wen), 32'(e.wen));
    chk({tag, ".zero"},   32'(bus.out_zero), 32'(e.zero));
    chk({tag, ".neg"},    32'(bus.out_negative), 32'(e.neg));
    chk({tag, ".exc"},    32'(bus.out_exc), 32'(e.exc));
  endtask

  task automatic drive(input instr_t i, input logic v);
    cur           = i;
    bus.in_valid  = v;
    bus.in_opcode = i.op;
    bus.in_funct  = i.fn;
    bus.in_shamt  = i.sh;
    bus.in_imm    = i.imm;
    bus.in_rs_val = i.rs;
    bus.in_rt_val = i.rt;
    bus.in_dst    = i.dst;
  endtask

  // One clock: sample handshakes at the falling edge, update the scoreboard,
  // return just after the rising edge.
  task automatic cycle(output logic acc);
    exp_t e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      chk("out_has_entry", {31'b0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        compare_out(e, "stream");
        n_out++;
      end
    end
    if (acc) q.push_back(model(cur));
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input string tag, input instr_t i, input logic [31:0] exp_res,
                           input logic [1:0] exp_exc);
    exp_t e;
    e = model(i);
    drive(i, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    drive(i, 1'b0);
    @(negedge clk);
    chk({tag, ".lat1_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, ".lat2_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".res_const"}, bus.out_result, exp_res);
    chk({tag, ".exc_const"}, 32'(bus.out_exc), 32'(exp_exc));
    chk({tag, ".wen_const"}, 32'(bus.out_wen), (exp_exc == 2'b00) ? 32'd1 : 32'd0);
    compare_out(e, tag);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"},  32'(bus.out_valid), 32'd0);
    chk({tag, ".result"}, bus.out_result, 32'd0);
    chk({tag, ".dst"},    32'(bus.out_dst), 32'd0);
    chk({tag, ".wen"},    32'(bus.out_wen), 32'd0);
    chk({tag, ".zero"},   32'(bus.out_zero), 32'd0);
    chk({tag, ".neg"},    32'(bus.out_negative), 32'd0);
    chk({tag, ".exc"},    32'(bus.out_exc), 32'd0);
  endtask

  task automatic fill_two(input instr_t a, input instr_t b);
    logic acc;
    int got;
    got = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      drive((got == 0) ? a : b, 1'b1);
      cycle(acc);
      if (acc) got++;
    end
    drive(b, 1'b0);
    chk("fill.accepted", 32'(got), 32'd2);
    chk("fill.in_ready_low", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    instr_t bp [4];
    instr_t ri;
    logic acc;
    logic v;
    int idx;
    int sent;
    int rand_out_base;

    drive(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h0, 32'h0, 5'd0), 1'b0);
    bus.out_ready = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);

    // Directed operations
    issue_one("add",   mk(6'h00, 6'h20, 5'd0, 16'h0,    32'h1c, 32'h21, 5'd3),
              32'h0000_003d, 2'b00);
    issue_one("sub",   mk(6'h00, 6'h22, 5'd0, 16'h0,    32'h1c, 32'h21, 5'd4),
              32'hffff_fffb, 2'b00);
    issue_one("add_ovf", mk(6'h00, 6'h20, 5'd0, 16'h0,  32'h7fff_ffff, 32'h1, 5'd5),
              32'h8000_0000, 2'b01);
    issue_one("addu",  mk(6'h00, 6'h21, 5'd0, 16'h0,    32'h7fff_ffff, 32'h1, 5'd6),
              32'h8000_0000, 2'b00);
    issue_one("lui",   mk(6'h0f, 6'h00, 5'd0, 16'h1234, 32'hdead_beef, 32'h0, 5'd7),
              32'h1234_0000, 2'b00);
    issue_one("sll",   mk(6'h00, 6'h00, 5'd4, 16'h0,    32'h5555_5555, 32'h21, 5'd8),
              32'h0000_0210, 2'b00);
    issue_one("addi",  mk(6'h08, 6'h00, 5'd0, 16'hffff, 32'h10, 32'h0, 5'd9),
              32'h0000_000f, 2'b00);
    issue_one("rsvd",  mk(6'h00, 6'h01, 5'd0, 16'h0,    32'h1234, 32'h5678, 5'd10),
              32'h0000_0000, 2'b10);

    // Backpressure: four ADDs with out_ready low for the first three cycles
    for (int k = 0; k < 4; k++)
      bp[k] = mk(6'h00, 6'h20, 5'd0, 16'h0, 32'(k + 1), 32'd100, 5'(k + 1));
    q.delete();
    n_out = 0;
    idx = 0;
    for (int c = 0; c < 30 && n_out < 4; c++) begin
      bus.out_ready = (c >= 3);
      if (c == 2) begin
        chk("bp.held", 32'(idx), 32'd2);
        chk("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      drive(bp[(idx < 4) ? idx : 0], idx < 4);
      cycle(acc);
      if (acc) idx++;
    end
    drive(bp[0], 1'b0);
    chk("bp.count", 32'(n_out), 32'd4);
    chk("bp.queue_empty", 32'(q.size()), 32'd0);

    // Asynchronous reset with both stages full
    fill_two(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h100, 32'h23, 5'd11),
             mk(6'h00, 6'h25, 5'd0, 16'h0, 32'hf0f0, 32'h0f0f, 5'd12));
    @(negedge clk);
    chk("rst_mid.valid_before", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue_one("after_rst", mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h1c, 32'h21, 5'd13),
              32'h0000_003d, 2'b00);

    // Synchronous flush with both stages full and an instruction offered
    fill_two(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h1, 32'h2, 5'd14),
             mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h3, 32'h4, 5'd15));
    drive(mk(6'h00, 6'h20, 5'd0, 16'h0, 32'h5, 32'h6, 5'd16), 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush.valid_before", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive(cur, 1'b0);
    bus.out_ready = 1'b1;
    chk("flush.valid", 32'(bus.out_valid), 32'd0);
    chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("flush.dropped", 32'(bus.out_valid), 32'd0);
    q.delete();
    issue_one("after_flush", mk(6'h00, 6'h22, 5'd0, 16'h0, 32'h0, 32'h1, 5'd17),
              32'hffff_ffff, 2'b00);

    // Randomized stream with random valid gaps and backpressure
    q.delete();
    rand_out_base = n_out;
    sent = 0;
    v = 1'b0;
    ri = rand_instr();
    for (int c = 0; c < 4000 && sent < 300; c++) begin
      if (!v) v = ($urandom_range(0, 3) != 0);
      drive(ri, v);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) begin
        sent++;
        v = 1'b0;
        ri = rand_instr();
      end
    end
    drive(ri, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cycle(acc);
    chk("rand.sent", 32'(sent), 32'd300);
    chk("rand.count", 32'(n_out - rand_out_base), 32'(sent));
    chk("rand.queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
